// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port of the multi-cycle core.
// A transfer completes on the rising edge where mem_req && mem_ready.
interface multicycle_cpu_if #(parameter int N = 32) ();
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_cpu.sv
// FSM-sequenced MIPS-subset core (add/sub/and/or/slt, lw/sw/beq/addi/j).
// Fetch and data access share one request/ready memory port.
module multicycle_cpu #(
  parameter int           N        = 32,
  parameter int           NREG     = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                rst,
  multicycle_cpu_if.master    bus,
  output logic [N-1:0]        pc,
  output logic                halted,
  output logic                wb_valid,
  output logic [4:0]          wb_reg,
  output logic [N-1:0]        wb_data
);
  localparam int RW = $clog2(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_RWB, S_MEMADDR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_pc, r_a, r_b, r_alu, r_mdr;
  logic [31:0]   r_ir;
  logic [N-1:0]  r_regs [NREG];

  logic [5:0]    w_op, w_funct;
  logic [RW-1:0] w_rs, w_rt, w_rd, w_dst;
  logic [N-1:0]  w_imm, w_alu, w_wdata;
  logic          w_funct_ok, w_we, w_mem_state;

  assign w_op    = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_rs    = r_ir[21 +: RW];
  assign w_rt    = r_ir[16 +: RW];
  assign w_rd    = r_ir[11 +: RW];
  assign w_imm   = {{(N-16){r_ir[15]}}, r_ir[15:0]};

  always_comb begin
    w_funct_ok = 1'b0;
    case (w_funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  // Non-R-type uses of the ALU (addi, lw/sw address) are all A + sext(imm).
  always_comb begin
    w_alu = r_a + w_imm;
    if (w_op == OP_R) begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = ($signed(r_a) < $signed(r_b)) ? N'(1) : '0;
        default: ;
      endcase
    end
  end

  assign w_dst   = (r_state == S_RWB && w_op == OP_R) ? w_rd : w_rt;
  assign w_wdata = (r_state == S_MEMWB) ? r_mdr : r_alu;
  assign w_we    = (r_state == S_RWB || r_state == S_MEMWB) && (w_dst != '0);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_mdr   <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_we) r_regs[w_dst] <= w_wdata;
      case (r_state)
        S_FETCH: if (bus.mem_ready) begin
          r_ir    <= bus.mem_rdata[31:0];
          r_pc    <= r_pc + N'(4);
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          case (w_op)
            OP_R:         r_state <= w_funct_ok ? S_EXEC : S_HALT;
            OP_ADDI:      r_state <= S_EXEC;
            OP_LW, OP_SW: r_state <= S_MEMADDR;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_HALT;
          endcase
        end
        S_EXEC: begin
          r_alu   <= w_alu;
          r_state <= S_RWB;
        end
        S_RWB:   r_state <= S_FETCH;
        S_MEMADDR: begin
          r_alu   <= w_alu;
          r_state <= (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (bus.mem_ready) begin
          r_mdr   <= bus.mem_rdata;
          r_state <= S_MEMWB;
        end
        S_MEMWB: r_state <= S_FETCH;
        S_MEMWR: if (bus.mem_ready) r_state <= S_FETCH;
        // PC already holds the address of the following instruction here.
        S_BRANCH: begin
          if (r_a == r_b) r_pc <= r_pc + (w_imm << 2);
          r_state <= S_FETCH;
        end
        S_JUMP: begin
          r_pc    <= {r_pc[N-1:28], r_ir[25:0], 2'b00};
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Request is gated by reset so an aborted transfer drops without waiting for a clock.
  assign w_mem_state   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign bus.mem_req   = rst & w_mem_state;
  assign bus.mem_we    = bus.mem_req & (r_state == S_MEMWR);
  assign bus.mem_addr  = !bus.mem_req ? '0 : ((r_state == S_FETCH) ? r_pc : r_alu);
  assign bus.mem_wdata = bus.mem_we ? r_b : '0;

  assign pc       = r_pc;
  assign halted   = (r_state == S_HALT);
  assign wb_valid = w_we;
  assign wb_reg   = w_we ? 5'(w_dst) : 5'd0;
  assign wb_data  = w_we ? w_wdata : '0;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: instruction-level reference model expanded into a per-cycle
// expected trace, a wait-state memory, and directed programs with literal checks.
module tb_multicycle_cpu;
  localparam int MAXC = 200;
  localparam logic [63:0] HALTI = 64'h0000_0000_FC00_0000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_b, sel64, rst32, rst64;
  int   wst;
  assign rst32 = rst_b & ~sel64;
  assign rst64 = rst_b & sel64;

  multicycle_cpu_if #(.N(32)) if32 ();
  multicycle_cpu_if #(.N(64)) if64 ();

  logic [31:0] pc32, wbd32;
  logic [63:0] pc64, wbd64;
  logic        h32, h64, wv32, wv64;
  logic [4:0]  wr32, wr64;

  multicycle_cpu #(.N(32), .NREG(32), .RESET_PC(32'h0)) dut32 (
    .CLK(CLK), .rst(rst32), .bus(if32), .pc(pc32), .halted(h32),
    .wb_valid(wv32), .wb_reg(wr32), .wb_data(wbd32));
  multicycle_cpu #(.N(64), .NREG(8), .RESET_PC(64'h0)) dut64 (
    .CLK(CLK), .rst(rst64), .bus(if64), .pc(pc64), .halted(h64),
    .wb_valid(wv64), .wb_reg(wr64), .wb_data(wbd64));

  logic        o_req, o_we, o_halt, o_wbv;
  logic [4:0]  o_wbr;
  logic [63:0] o_addr, o_wdata, o_pc, o_wbd;
  always_comb begin
    if (sel64) begin
      o_req = if64.mem_req; o_we = if64.mem_we; o_addr = if64.mem_addr; o_wdata = if64.mem_wdata;
      o_pc = pc64; o_halt = h64; o_wbv = wv64; o_wbr = wr64; o_wbd = wbd64;
    end else begin
      o_req = if32.mem_req; o_we = if32.mem_we; o_addr = {32'd0, if32.mem_addr};
      o_wdata = {32'd0, if32.mem_wdata}; o_pc = {32'd0, pc32}; o_halt = h32;
      o_wbv = wv32; o_wbr = wr32; o_wbd = {32'd0, wbd32};
    end
  end

  // Memory with wst wait cycles per transfer
  logic [63:0] mem [0:127];
  logic [6:0]  idx;
  int          wcnt;
  logic        rdy;
  assign idx = o_addr[8:2];
  assign rdy = o_req && (wcnt >= wst);
  assign if32.mem_ready = rdy;
  assign if64.mem_ready = rdy;
  assign if32.mem_rdata = mem[idx][31:0];
  assign if64.mem_rdata = mem[idx];
  always @(posedge CLK) begin
    if (!o_req) wcnt <= 0;
    else if (rdy) begin
      if (o_we) mem[idx] = o_wdata;
      wcnt <= 0;
    end else wcnt <= wcnt + 1;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model state and expected per-cycle trace
  logic [63:0] mm [0:127];
  logic [63:0] mr [0:31];
  logic [63:0] mpc;
  int          tn;
  logic        t_req [MAXC], t_we [MAXC], t_halt [MAXC], t_wbv [MAXC];
  logic [4:0]  t_wbr [MAXC];
  logic [63:0] t_addr [MAXC], t_wdata [MAXC], t_pc [MAXC], t_wbd [MAXC];

  function automatic logic [63:0] msk();
    return sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] sxw(input logic [63:0] v);
    return sel64 ? v : {{32{v[31]}}, v[31:0]};
  endfunction

  task automatic push(input logic rq, input logic we, input logic [63:0] ad, input logic [63:0] wd,
                      input logic wv, input int wr, input logic [63:0] wdv, input logic hl);
    if (tn < MAXC) begin
      t_req[tn] = rq; t_we[tn] = we; t_addr[tn] = ad; t_wdata[tn] = wd;
      t_wbv[tn] = wv; t_wbr[tn] = 5'(wr); t_wbd[tn] = wdv; t_halt[tn] = hl; t_pc[tn] = mpc;
    end
    tn++;
  endtask

  task automatic idle();
    push(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
  endtask

  task automatic mwrite(input int r, input logic [63:0] v);
    push(1'b0, 1'b0, 64'd0, 64'd0, r != 0, r, v, 1'b0);
    if (r != 0) mr[r] = v;
  endtask

  task automatic model_build(input int W, input int L);
    logic [31:0] ins;
    logic [63:0] a, b, imm, ea, v;
    int rs, rt, rd, nm;
    logic ok;
    nm = sel64 ? 7 : 31;
    for (int i = 0; i < 32; i++) mr[i] = 64'd0;
    mpc = 64'd0;
    tn  = 0;
    while (tn < L) begin
      ins = mm[mpc[8:2]][31:0];
      for (int w = 0; w <= W; w++) push(1'b1, 1'b0, mpc, 64'd0, 1'b0, 0, 64'd0, 1'b0);
      mpc = (mpc + 64'd4) & msk();
      idle();
      rs = int'(ins[25:21]) & nm; rt = int'(ins[20:16]) & nm; rd = int'(ins[15:11]) & nm;
      a = mr[rs]; b = mr[rt];
      imm = {{48{ins[15]}}, ins[15:0]};
      ok = 1'b1; v = 64'd0;
      if (ins[31:26] == 6'h00) begin
        case (ins[5:0])
          6'h20: v = (a + b) & msk();
          6'h22: v = (a - b) & msk();
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = ($signed(sxw(a)) < $signed(sxw(b))) ? 64'd1 : 64'd0;
          default: ok = 1'b0;
        endcase
        if (ok) begin idle(); mwrite(rd, v); end
      end else if (ins[31:26] == 6'h08) begin
        idle(); mwrite(rt, (a + imm) & msk());
      end else if (ins[31:26] == 6'h23) begin
        ea = (a + imm) & msk(); idle();
        for (int w = 0; w <= W; w++) push(1'b1, 1'b0, ea, 64'd0, 1'b0, 0, 64'd0, 1'b0);
        mwrite(rt, mm[ea[8:2]] & msk());
      end else if (ins[31:26] == 6'h2B) begin
        ea = (a + imm) & msk(); idle();
        for (int w = 0; w <= W; w++) push(1'b1, 1'b1, ea, b, 1'b0, 0, 64'd0, 1'b0);
        mm[ea[8:2]] = b;
      end else if (ins[31:26] == 6'h04) begin
        idle();
        if (a == b) mpc = (mpc + (imm << 2)) & msk();
      end else if (ins[31:26] == 6'h02) begin
        idle();
        mpc = ((mpc & ~64'h0FFF_FFFF) | {36'd0, ins[25:0], 2'b00}) & msk();
      end else ok = 1'b0;
      if (!ok) while (tn < L) push(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    end
  endtask

  // Instruction encoders and memory loading
  function automatic logic [63:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {32'd0, op[5:0], rs[4:0], rt[4:0], imm};
  endfunction
  function automatic logic [63:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {32'd0, 6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic logic [63:0] enc_j(input int tgt);
    return {32'd0, 6'h02, tgt[25:0]};
  endfunction
  task automatic clear_mem();
    for (int i = 0; i < 128; i++) begin mem[i] = 64'd0; mm[i] = 64'd0; end
  endtask
  task automatic put(input int w, input logic [63:0] v);
    mem[w] = v; mm[w] = v;
  endtask
  task automatic load_s1(input int base);
    put(base,     enc_i(8, 0, 1, 16'd5));
    put(base + 1, enc_i(8, 0, 2, 16'hFFFD));
    put(base + 2, enc_r(1, 2, 3, 32'h20));
  endtask

  // DUT-side recordings for the literal checks
  int          ev_cyc[$], ev_reg[$];
  logic [63:0] ev_dat[$];
  logic        rec_req [0:63];
  logic [63:0] rec_addr [0:63];
  int          first_halt;

  task automatic run(input int L);
    ev_cyc.delete(); ev_reg.delete(); ev_dat.delete();
    first_halt = 0;
    @(posedge CLK); #1 rst_b = 1'b1;
    for (int c = 1; c <= L; c++) begin
      @(negedge CLK);
      chk($sformatf("req@%0d", c), 64'(o_req), 64'(t_req[c-1]));
      chk($sformatf("pc@%0d", c), o_pc, t_pc[c-1]);
      chk($sformatf("halted@%0d", c), 64'(o_halt), 64'(t_halt[c-1]));
      chk($sformatf("wb_valid@%0d", c), 64'(o_wbv), 64'(t_wbv[c-1]));
      if (t_wbv[c-1]) begin
        chk($sformatf("wb_reg@%0d", c), 64'(o_wbr), 64'(t_wbr[c-1]));
        chk($sformatf("wb_data@%0d", c), o_wbd, t_wbd[c-1]);
      end
      if (t_req[c-1]) begin
        chk($sformatf("mem_we@%0d", c), 64'(o_we), 64'(t_we[c-1]));
        chk($sformatf("mem_addr@%0d", c), o_addr, t_addr[c-1]);
        if (t_we[c-1]) chk($sformatf("mem_wdata@%0d", c), o_wdata, t_wdata[c-1]);
      end
      if (c < 64) begin rec_req[c] = o_req; rec_addr[c] = o_addr; end
      if (o_wbv) begin ev_cyc.push_back(c); ev_reg.push_back(int'(o_wbr)); ev_dat.push_back(o_wbd); end
      if (o_halt && first_halt == 0) first_halt = c;
    end
  endtask

  task automatic lit_ev(input string nm, input int k, input int cyc, input int r, input logic [63:0] d);
    int ac, ar;
    logic [63:0] ad;
    ac = -1; ar = -1; ad = 64'hDEAD_DEAD_DEAD_DEAD;
    if (k < ev_cyc.size()) begin ac = ev_cyc[k]; ar = ev_reg[k]; ad = ev_dat[k]; end
    chk({nm, "_cycle"}, 64'(ac), 64'(cyc));
    chk({nm, "_reg"}, 64'(ar), 64'(r));
    chk({nm, "_data"}, ad, d);
  endtask

  task automatic reset_dut();
    rst_b = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_b = 1'b0; sel64 = 1'b0; wst = 0;
    clear_mem();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_req", 64'(o_req), 64'd0);
    chk("reset_pc", o_pc, 64'd0);
    chk("reset_halted", 64'(o_halt), 64'd0);
    chk("reset_wb_valid", 64'(o_wbv), 64'd0);
    chk("reset_addr", o_addr, 64'd0);

    // Three ALU writebacks, then an illegal opcode
    clear_mem(); load_s1(0); put(3, HALTI);
    model_build(0, 18); run(18);
    chk("s1_wb_count", 64'(ev_cyc.size()), 64'd3);
    lit_ev("s1_wb0", 0, 4, 1, 64'd5);
    lit_ev("s1_wb1", 1, 8, 2, 64'h0000_0000_FFFF_FFFD);
    lit_ev("s1_wb2", 2, 12, 3, 64'd2);
    chk("s1_halt_cycle", 64'(first_halt), 64'd15);

    // Store then load through a two-wait-state memory
    reset_dut(); wst = 2;
    clear_mem(); put(0, enc_j(32'h10)); load_s1(16);
    put(19, enc_i(32'h2B, 0, 3, 16'd8)); put(20, enc_i(32'h23, 0, 4, 16'd8)); put(21, HALTI);
    model_build(2, 50); run(50);
    chk("s2_store_word", mem[2], 64'd2);
    chk("s2_wb_count", 64'(ev_cyc.size()), 64'd4);
    lit_ev("s2_lw", 3, 40, 4, 64'd2);

    // Not-taken branch followed by a self-loop
    reset_dut(); wst = 0;
    clear_mem(); load_s1(0);
    put(2, enc_i(4, 1, 2, 16'd2)); put(3, enc_i(8, 0, 6, 16'd7)); put(4, enc_i(4, 1, 1, 16'hFFFF));
    model_build(0, 30); run(30);
    chk("s3_nt_fetch", rec_addr[12], 64'h0C);
    chk("s3_loop0", rec_addr[16], 64'h10);
    chk("s3_loop1", rec_addr[19], 64'h10);
    chk("s3_loop2", rec_addr[22], 64'h10);
    lit_ev("s3_addi", 2, 15, 6, 64'd7);

    // Jump, slt/or/and, and a discarded write to $0
    reset_dut();
    clear_mem(); put(0, enc_i(8, 0, 1, 16'd5)); put(1, enc_i(8, 0, 2, 16'hFFFD)); put(2, enc_j(32'h40));
    put(64, enc_r(2, 1, 5, 32'h2A)); put(65, enc_r(1, 2, 6, 32'h25)); put(66, enc_r(1, 2, 7, 32'h24));
    put(67, enc_r(1, 1, 0, 32'h22)); put(68, enc_i(8, 0, 9, 16'd9)); put(69, HALTI);
    model_build(0, 40); run(40);
    chk("s4_jump_fetch", rec_addr[12], 64'h100);
    chk("s4_wb_count", 64'(ev_cyc.size()), 64'd6);
    lit_ev("s4_slt", 2, 15, 5, 64'd1);
    lit_ev("s4_or", 3, 19, 6, 64'h0000_0000_FFFF_FFFD);
    lit_ev("s4_r0", 5, 31, 9, 64'd9);

    // Reset pulse in the middle of a load's wait states
    reset_dut(); wst = 3;
    clear_mem(); put(0, enc_i(32'h23, 0, 4, 16'd8)); put(1, HALTI); put(2, 64'h1234);
    model_build(3, 20); run(8);
    chk("s5_memrd_req", 64'(rec_req[8]), 64'd1);
    chk("s5_memrd_addr", rec_addr[8], 64'd8);
    @(posedge CLK); #1 rst_b = 1'b0;
    #1;
    chk("s5_abort_req", 64'(o_req), 64'd0);
    chk("s5_abort_pc", o_pc, 64'd0);
    run(20);
    chk("s5_refetch_req", 64'(rec_req[1]), 64'd1);
    chk("s5_refetch_addr", rec_addr[1], 64'd0);
    lit_ev("s5_lw", 0, 11, 4, 64'h1234);

    // First program again on the 64-bit, 8-register build
    reset_dut(); sel64 = 1'b1; wst = 0;
    repeat (2) @(posedge CLK); #1;
    clear_mem(); load_s1(0); put(3, HALTI);
    model_build(0, 18); run(18);
    lit_ev("s6_wb0", 0, 4, 1, 64'd5);
    lit_ev("s6_wb1", 1, 8, 2, 64'hFFFF_FFFF_FFFF_FFFD);
    lit_ev("s6_wb2", 2, 12, 3, 64'd2);
    chk("s6_halt_cycle", 64'(first_halt), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle MIPS-subset core that replaces the single-cycle datapath with an FSM-sequenced datapath. Instruction fetch and data access share one memory port with a request/ready handshake, so slow memories insert wait states. The block is the next-generation CPU top. It has internal PC, IR, register file, ALU and control FSM, and it exposes architectural state for the benches.

## Interface

Parameters:
- `N`, 32, datapath/register width; must be ≥ 32; instruction occupies `mem_rdata[31:0]`
- `NREG`, 32, register count; must be a power of 2 ≤ 32; register index = low log2(NREG) bits of rs/rt/rd fields
- `RESET_PC`, 0, PC value after reset

Ports:
- `CLK`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mem_req`  out  1  memory transfer requested this cycle
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  N  byte address, word-aligned
- `mem_wdata`  out  N  store data
- `mem_rdata`  in  N  read data, sampled on the completing edge
- `mem_ready`  in  1  transfer completes on the edge where `mem_req && mem_ready`
- `pc`  out  N  current PC
- `halted`  out  1  core stopped on an illegal opcode
- `wb_valid`  out  1  one-cycle pulse when a register write occurs
- `wb_reg`  out  5  destination index of that write
- `wb_data`  out  N  value written

## Operation

Supported instructions (MIPS encodings):
- R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed)
- I-type: `lw` 0x23, `sw` 0x2B, `beq` 0x04, `addi` 0x08
- J-type: `j` 0x02
- Any other opcode or funct puts the core in HALT.

Arithmetic:
- All arithmetic is modulo 2^N; overflow is ignored.
- The immediate is sign-extended to N.
- Branch target = PC(already +4) + (sext(imm) << 2).
- Jump target = {PC[N-1:28], instr[25:0], 2'b00}.

Register file:
- Register 0 reads as 0; writes to it are discarded and `wb_valid` does not pulse.
- Reads are combinational.
- Writes take effect on the rising edge.

FSM states and transitions:
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. Wait while `!mem_ready`. On completion: IR ← `mem_rdata[31:0]`, PC ← PC+4, go to DECODE.
- DECODE: latch A ← R[rs] and B ← R[rt]. Then go to:
  - EXEC for R-type or `addi`
  - MEMADDR for `lw`/`sw`
  - BRANCH for `beq`
  - JUMP for `j`
  - HALT for anything else
- EXEC: ALUOut ← A op (B or sext imm); go to RWB.
- RWB: R[rd] (R-type) or R[rt] (`addi`) ← ALUOut; pulse `wb_*`; go to FETCH.
- MEMADDR: ALUOut ← A + sext(imm); go to MEMRD (`lw`) or MEMWR (`sw`).
- MEMRD: `mem_req`=1, `mem_we`=0, `mem_addr`=ALUOut. Wait for ready; MDR ← `mem_rdata`; go to MEMWB.
- MEMWB: R[rt] ← MDR; pulse `wb_*`; go to FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `mem_addr`=ALUOut, `mem_wdata`=B. Wait for ready; go to FETCH.
- BRANCH: if A == B, PC ← branch target; go to FETCH.
- JUMP: PC ← jump target; go to FETCH.
- HALT: absorbing state; `halted`=1, `mem_req`=0. Only reset exits.

Reset:
- Asserting `rst` low clears the state to FETCH and sets PC to `RESET_PC`.
- IR, A, B, ALUOut and MDR clear to 0; all registers clear to 0.
- All outputs are 0 except `pc` = `RESET_PC`.
- Reset mid-transfer aborts the transfer; `mem_req` drops immediately (asynchronously).

## Timing

- Cycle counts at zero wait (`mem_ready` held 1):
  - R-type/`addi`: 4
  - `lw`: 5
  - `sw`: 4
  - `beq`: 3
  - `j`: 3
- Each wait cycle (`mem_req` && !`mem_ready`) adds one cycle.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable for the whole request.
- `mem_req` is never asserted in two consecutive transfers without an intervening non-memory state, except for a `sw` MEMWR followed by the next FETCH.
- `wb_valid` is high for exactly one cycle, during RWB or MEMWB. The written value is visible to a read in the following cycle.
- First FETCH request occurs in the first cycle after `rst` deasserts.

## Test plan

- Reset then `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` with zero-wait memory → `wb_*` pulses (1,5), (2,0xFFFFFFFD), (3,2). Retire at cycles 4, 8, 12.
- `sw $3,8($0)`; `lw $4,8($0)` with `mem_ready` low for 2 cycles on every transfer → store writes 2 to address 8. `wb` gives (4,2). Each wait cycle holds address/data stable.
- `beq $1,$1,-1` loop, then `beq $1,$2,+2` not taken → PC repeats the same address every 3 cycles. In the not-taken case PC advances by 4 only.
- `j 0x40` → next `mem_addr` = 0x100. `slt $5,$2,$1` → `wb` (5,1); `sub $0,$1,$1` → no `wb_valid`, R0 still 0.
- Illegal opcode 0x3F → `halted`=1 two cycles after fetch completes, `mem_req` stays 0. Pulsing `rst` low mid-MEMRD → `pc` = `RESET_PC`, `mem_req` drops at once, and the core refetches after release.
- Rerun the first scenario with N=64, NREG=8 → same results sign-extended to 64 bits.
